// File: rtl/tessia_exec_pkg.sv
// Shared types and constants for the TessiaX64 execute stage.
package tessia_exec_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'b0000,
        OpSub = 4'b0001,
        OpAnd = 4'b0010,
        OpOr  = 4'b0011,
        OpXor = 4'b0100,
        OpShl = 4'b0101,
        OpShr = 4'b0110,
        OpMul = 4'b0111
    } alu_op_t;

    typedef enum logic [1:0] {
        FwdReg     = 2'b00,
        FwdResultW = 2'b01,
        FwdAluM    = 2'b10,
        FwdRegAlt  = 2'b11
    } fwd_sel_t;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } exec_state_t;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits kept.
module mul_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             busy,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CntW-1:0]  count_q;

    // Accumulator plus the current partial product; on the last step this is the result
    always_comb begin
        product = acc_q + (mplier_q[0] ? mcand_q : '0);
        done    = busy && (count_q == '0);
    end

    // Load operands on start, then shift multiplicand left / multiplier right each step
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            count_q  <= CntW'(WIDTH - 1);
        end else if (busy && (count_q != '0)) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/execute_stage_mc.sv
// Execute stage with forwarding, single-cycle ALU, iterative MUL and EX/MEM register.
module execute_stage_mc import tessia_exec_pkg::*; #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidE,
    input  logic             FlushE,
    input  logic             ALUSrcE,
    input  logic             FlagWriteE,
    input  logic [3:0]       ALUControlE,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [WIDTH-1:0] ExtImmE,
    input  logic [WIDTH-1:0] ResultW,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic             ValidM,
    output logic [3:0]       FlagsM,
    output logic             StallE
);

    localparam int unsigned ShW = $clog2(WIDTH);

    alu_op_t          op;
    exec_state_t      state_q;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b_fwd;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   sum;
    logic             carry;
    logic             ovf;
    logic [3:0]       alu_flags;
    logic [3:0]       mul_flags;
    logic [WIDTH-1:0] mul_prod;
    logic             mul_req;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;

    // Forwarding muxes and B operand select
    always_comb begin
        op = alu_op_t'(ALUControlE);
        case (fwd_sel_t'(ForwardAE))
            FwdResultW: a = ResultW;
            FwdAluM:    a = ALUResultM;
            default:    a = SrcAE;
        endcase
        case (fwd_sel_t'(ForwardBE))
            FwdResultW: b_fwd = ResultW;
            FwdAluM:    b_fwd = ALUResultM;
            default:    b_fwd = WriteDataE;
        endcase
        b = ALUSrcE ? ExtImmE : b_fwd;
    end

    // Single-cycle ALU; MUL and undefined codes yield zero here
    always_comb begin
        alu_res = '0;
        sum     = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        case (op)
            OpAdd: begin
                sum     = {1'b0, a} + {1'b0, b};
                alu_res = sum[WIDTH-1:0];
                carry   = sum[WIDTH];
                ovf     = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OpSub: begin
                // Carry out of a + ~b + 1 is the no-borrow flag
                sum     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum[WIDTH-1:0];
                carry   = sum[WIDTH];
                ovf     = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OpAnd:   alu_res = a & b;
            OpOr:    alu_res = a | b;
            OpXor:   alu_res = a ^ b;
            OpShl:   alu_res = a << b[ShW-1:0];
            OpShr:   alu_res = a >> b[ShW-1:0];
            default: alu_res = '0;
        endcase
        alu_flags        = '0;
        alu_flags[FlagN] = alu_res[WIDTH-1];
        alu_flags[FlagZ] = (alu_res == '0);
        alu_flags[FlagC] = carry;
        alu_flags[FlagV] = ovf;
        mul_flags        = '0;
        mul_flags[FlagN] = mul_prod[WIDTH-1];
        mul_flags[FlagZ] = (mul_prod == '0);
    end

    // Multiply handshake and upstream stall
    always_comb begin
        mul_req   = ValidE && (op == OpMul) && MUL_EN;
        mul_busy  = (state_q == StBusy);
        mul_start = (state_q == StIdle) && mul_req && !FlushE && !reset;
        StallE    = !reset && !FlushE &&
                    (((state_q == StIdle) && mul_req) || (mul_busy && !mul_done));
    end

    mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul_iter (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .busy    (mul_busy),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // FSM and EX/MEM register: reset > flush > stall bubble > MUL completion > normal load
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ALUResultM <= '0;
            WriteDataM <= '0;
            ValidM     <= 1'b0;
            FlagsM     <= '0;
        end else if (FlushE) begin
            state_q <= StIdle;
            ValidM  <= 1'b0;
        end else if (StallE) begin
            ValidM <= 1'b0;
            if (mul_start) begin
                state_q <= StBusy;
            end
        end else if (mul_busy) begin
            state_q    <= StIdle;
            ValidM     <= 1'b1;
            ALUResultM <= mul_prod;
            if (FlagWriteE) begin
                FlagsM <= mul_flags;
            end
        end else begin
            ValidM <= ValidE;
            if (ValidE) begin
                ALUResultM <= alu_res;
                WriteDataM <= b_fwd;
                if (FlagWriteE) begin
                    FlagsM <= alu_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Self-checking bench for execute_stage_mc at WIDTH=8 against an arithmetic reference model.
module tb_execute_stage_mc;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         ValidE, FlushE, ALUSrcE, FlagWriteE;
    logic [3:0]   ALUControlE;
    logic [1:0]   ForwardAE, ForwardBE;
    logic [W-1:0] SrcAE, WriteDataE, ExtImmE, ResultW;
    logic [W-1:0] ALUResultM, WriteDataM;
    logic         ValidM;
    logic [3:0]   FlagsM;
    logic         StallE;

    int vectors = 0;
    int miscompares = 0;

    // Reference copy of the EX/MEM contents
    logic [7:0] m_res   = '0;
    logic [3:0] m_flags = '0;

    execute_stage_mc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .ValidE      (ValidE),
        .FlushE      (FlushE),
        .ALUSrcE     (ALUSrcE),
        .FlagWriteE  (FlagWriteE),
        .ALUControlE (ALUControlE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .SrcAE       (SrcAE),
        .WriteDataE  (WriteDataE),
        .ExtImmE     (ExtImmE),
        .ResultW     (ResultW),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .ValidM      (ValidM),
        .FlagsM      (FlagsM),
        .StallE      (StallE)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sx(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Returns {NZCV, result} for an 8-bit op, from plain integer arithmetic
    function automatic logic [11:0] ref_alu(input int op, input int a, input int b);
        int r, s;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            0: begin s = a + b; r = s % 256; c = (s > 255);
                     s = sx(a) + sx(b); v = (s > 127) || (s < -128); end
            1: begin r = (a - b + 256) % 256; c = (a >= b);
                     s = sx(a) - sx(b); v = (s > 127) || (s < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (a * (1 << (b % 8))) % 256;
            6: r = a / (1 << (b % 8));
            7: r = (a * b) % 256;
            default: r = 0;
        endcase
        return {(r >= 128), (r == 0), c, v, 8'(r)};
    endfunction

    task automatic scramble();
        SrcAE      = 8'($urandom);
        WriteDataE = 8'($urandom);
        ExtImmE    = 8'($urandom);
        ResultW    = 8'($urandom);
        ForwardAE  = 2'($urandom);
        ForwardBE  = 2'($urandom);
        ALUSrcE    = 1'($urandom);
    endtask

    task automatic drive(input int op, input int srca, input int wd, input int imm, input int resw,
                         input int fa, input int fb, input int alusrc, input int fw, input int valid,
                         input int flush);
        ALUControlE = 4'(op);
        SrcAE       = 8'(srca);
        WriteDataE  = 8'(wd);
        ExtImmE     = 8'(imm);
        ResultW     = 8'(resw);
        ForwardAE   = 2'(fa);
        ForwardBE   = 2'(fb);
        ALUSrcE     = 1'(alusrc);
        FlagWriteE  = 1'(fw);
        ValidE      = 1'(valid);
        FlushE      = 1'(flush);
    endtask

    // Applies one instruction at the current cycle and checks it through to EX/MEM
    task automatic run_op(input int op, input int srca, input int wd, input int imm, input int resw,
                          input int fa, input int fb, input int alusrc, input int fw,
                          input int valid, input int flush);
        int a, bf, b;
        logic [11:0] r;
        drive(op, srca, wd, imm, resw, fa, fb, alusrc, fw, valid, flush);
        a  = (fa == 1) ? resw : (fa == 2) ? int'(m_res) : srca;
        bf = (fb == 1) ? resw : (fb == 2) ? int'(m_res) : wd;
        b  = (alusrc != 0) ? imm : bf;
        r  = ref_alu(op, a, b);
        #1;
        if (flush != 0) begin
            chk("stall_flush", StallE, 0);
            step();
            chk("valid_flush", ValidM, 0);
            chk("flags_flush", FlagsM, m_flags);
        end else if ((valid != 0) && (op == 7)) begin
            chk("stall_mul_c0", StallE, 1);
            for (int i = 1; i <= W; i++) begin
                step();
                chk("valid_mul_busy", ValidM, 0);
                scramble();
                #1;
                chk("stall_mul", StallE, (i < W) ? 1 : 0);
            end
            step();
            m_res = r[7:0];
            if (fw != 0) m_flags = r[11:8];
            chk("mul_res", ALUResultM, m_res);
            chk("mul_valid", ValidM, 1);
            chk("mul_flags", FlagsM, m_flags);
        end else begin
            chk("stall_single", StallE, 0);
            step();
            if (valid != 0) begin
                m_res = r[7:0];
                if (fw != 0) m_flags = r[11:8];
                chk("alu_res", ALUResultM, m_res);
                chk("alu_wdata", WriteDataM, bf);
                chk("alu_valid", ValidM, 1);
            end else begin
                chk("bubble_res_hold", ALUResultM, m_res);
                chk("bubble_valid", ValidM, 0);
            end
            chk("alu_flags", FlagsM, m_flags);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        // StallE must stay low during reset even with a MUL presented
        drive(7, 3, 3, 0, 0, 0, 0, 0, 1, 1, 0);
        #1;
        chk("reset_stall", StallE, 0);
        step();
        chk("reset_res", ALUResultM, 0);
        chk("reset_wdata", WriteDataM, 0);
        chk("reset_valid", ValidM, 0);
        chk("reset_flags", FlagsM, 0);
        reset = 1'b0;
        ValidE = 1'b0;

        // ADD 0x7F + 0x01 via immediate
        run_op(0, 'h7F, 0, 'h01, 0, 0, 0, 1, 1, 1, 0);
        chk("t1_res", ALUResultM, 'h80);
        chk("t1_flags", FlagsM, 4'b1001);

        // SUB 5-5, then SUB without flag write
        run_op(1, 5, 5, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("t2_res", ALUResultM, 'h00);
        chk("t2_flags", FlagsM, 4'b0110);
        run_op(1, 7, 2, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("t2b_res", ALUResultM, 'h05);
        chk("t2b_flags", FlagsM, 4'b0110);

        // Forwarding from ResultW, then immediate B, then A from ALUResultM
        run_op(0, 3, 'h55, 0, 'h10, 0, 1, 0, 1, 1, 0);
        chk("t4_res", ALUResultM, 'h13);
        chk("t4_wdata", WriteDataM, 'h10);
        run_op(0, 3, 'h55, 'h20, 'h10, 0, 1, 1, 1, 1, 0);
        chk("t4b_res", ALUResultM, 'h23);
        chk("t4b_wdata", WriteDataM, 'h10);
        run_op(0, 0, 1, 0, 0, 2, 0, 0, 1, 1, 0);
        chk("t4c_res", ALUResultM, 'h24);

        // MUL 0x0D * 0x0B
        run_op(7, 'h0D, 'h0B, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("t3_res", ALUResultM, 'h8F);
        chk("t3_flags", FlagsM, 4'b1000);

        // Flush at cycle 3 of a MUL
        drive(7, 9, 9, 0, 0, 0, 0, 0, 1, 1, 0);
        step();
        step();
        step();
        FlushE = 1'b1;
        #1;
        chk("t5_stall", StallE, 0);
        step();
        FlushE = 1'b0;
        chk("t5_valid", ValidM, 0);
        chk("t5_flags", FlagsM, m_flags);
        run_op(0, 2, 3, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("t5_add", ALUResultM, 'h05);

        // Reset at cycle 4 of a MUL
        drive(7, 6, 7, 0, 0, 0, 0, 0, 1, 1, 0);
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("t6_stall", StallE, 0);
        step();
        reset = 1'b0;
        ValidE = 1'b0;
        #1;
        chk("t6_res", ALUResultM, 0);
        chk("t6_wdata", WriteDataM, 0);
        chk("t6_valid", ValidM, 0);
        chk("t6_flags", FlagsM, 0);
        chk("t6_stall_after", StallE, 0);
        m_res = '0;
        m_flags = '0;
        run_op(7, 'h0D, 'h0B, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("t6_mul", ALUResultM, 'h8F);

        // Randomized mix including bubbles, flushes, undefined opcodes and MUL
        for (int n = 0; n < 60; n++) begin
            int op;
            op = ($urandom_range(0, 3) == 0) ? 7 : int'($urandom_range(0, 15));
            run_op(op, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) != 0) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
